rr_arb_mux: RTL and testbench

- Parametrised N-channel arbitrated selector with a registered output and valid/ready handshakes.
- Multiple requesters compete for a single output. For example, instruction fetch, data access and DMA all sharing one memory port in the CPU datapath.
- Each cycle it picks one valid input by round-robin or fixed priority, captures that input's data into an output register, and reports which channel won.

---
 rtl/rr_arb_mux.sv | 79 +++++++
 tb/tb_rr_arb_mux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated selector: round-robin or fixed-priority grant feeding a
// one-entry output register with valid/ready handshakes on both sides.
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SELW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_sel,
  input  logic                    out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt;
  logic             gnt_vld;
  logic             load_en;
  logic [WIDTH-1:0] ch_data [NUM_CH];

  assign load_en = !out_valid || out_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Visit channels in priority order; the first valid one wins. Fixed mode
  // starts the search at 0, round-robin starts at ptr and wraps.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = mode ? i : (32'(ptr) + i) % NUM_CH;
      if (!gnt_vld && in_valid[SELW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt     = SELW'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load_en && gnt_vld) begin
      in_ready[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt];
        out_sel   <= gnt;
        if (!mode) begin
          ptr <= (gnt == SELW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomized and directed bench for rr_arb_mux against a distance-based
// arbitration model; directed phases also check fixed expected sequences.
module tb_rr_arb_mux;
  localparam int WIDTH  = 32;
  localparam int NUM_CH = 4;
  localparam int SELW   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_sel;
  logic                    out_ready;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_data;
  int          m_sel;

  rr_arb_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner = valid channel with the smallest distance from the search origin.
  function automatic int model_grant();
    int best  = -1;
    int bestd = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_valid[c]) begin
        int d = mode ? c : (c - m_ptr + NUM_CH) % NUM_CH;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ready();
    int g = model_grant();
    logic [NUM_CH-1:0] r = '0;
    if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g = model_grant();
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_sel   = g;
        if (!mode) m_ptr = (g + 1) % NUM_CH;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Check at negedge, advance the model on posedge, return 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    chk("in_ready", in_ready, model_ready());
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = base + i;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = '1; out_ready = 1'b1;
    set_data(32'hA0);
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);

    // round-robin fairness, one word per cycle
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_sel", out_sel, k % 4);
      chk("rr_data", out_data, 32'hA0 + k % 4);
      chk("rr_valid", out_valid, 1);
    end

    // wrap/skip: ptr lands on 3 after channel 2, then 0101 alternates 0,2,0
    in_valid = 4'b0100; cycle();
    chk("wrap_pre", out_sel, 2);
    in_valid = 4'b0101;
    cycle(); chk("wrap0", out_sel, 0);
    cycle(); chk("wrap1", out_sel, 2);
    cycle(); chk("wrap2", out_sel, 0);

    // fixed priority starves 2 and 3; ptr (left at 2) is untouched meanwhile
    in_valid = 4'b0010; cycle();
    mode = 1'b1; in_valid = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      cycle(); chk("fix_sel", out_sel, 1);
    end
    mode = 1'b0; cycle();
    chk("fix_to_rr", out_sel, 2);

    // backpressure holds the word and blocks all requesters
    in_valid = 4'b1000; in_data[3*WIDTH +: WIDTH] = 32'hDEADBEEF; cycle();
    chk("bp_load", out_data, 32'hDEADBEEF);
    set_data(32'h100); out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_data", out_data, 32'hDEADBEEF);
      chk("bp_sel", out_sel, 3);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1; cycle();
    chk("bp_refill_sel", out_sel, 0);
    chk("bp_refill_data", out_data, 32'h100);

    // idle drain keeps data/sel, then reset mid-transfer
    in_valid = '0; cycle();
    chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, 32'h100);
    in_valid = 4'b0010; cycle();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1; in_valid = '1; cycle();
    chk("mid_rst_valid", out_valid, 0);
    rst = 1'b0; cycle();
    chk("post_rst_sel", out_sel, 0);
    chk("post_rst_valid", out_valid, 1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mode      = ($urandom_range(0, 3) == 0);
      in_valid  = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
